rr_arb8: RTL
============

RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 The block SHALL have parameter PTR_INIT, default 0, meaning the index (0..7) holding highest priority after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port nreset, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port req, input, 8, per-requester request; bit i means requester i holds a beat.
REQ-005 The block SHALL have port last, input, 8, per-requester final-beat flag, sampled only for the granted requester.
REQ-006 The block SHALL have port ready, input, 1, downstream accepts the current beat this cycle.
REQ-007 The block SHALL have port grant, output, 8, registered one-hot grant, wired directly to the downstream one-hot mux selects sel0..sel7.
REQ-008 The block SHALL have port grant_id, output, 3, binary index of the set grant bit; 0 when grant is 0.
REQ-009 The block SHALL have port valid, output, 1, equal to |(grant & req).

Function
REQ-010 grant SHALL be zero or exactly one-hot in every cycle.
REQ-011 States SHALL be IDLE (grant=0) and BUSY (grant nonzero).
REQ-012 In IDLE with req nonzero, the block SHALL load grant with the round-robin winner one cycle later and enter BUSY; with req zero it SHALL stay IDLE.
REQ-013 Winner SHALL be the first set req bit scanning upward from pointer ptr, wrapping 7->0.
REQ-014 A transfer SHALL be a cycle with valid=1 and ready=1.
REQ-015 Release SHALL occur on a releasing transfer (REQ-024/025) or when the granted req bit is 0 (abandon).
REQ-016 On release, ptr SHALL become (granted index + 1) mod 8, and the next-cycle grant SHALL be the winner among current req computed with the new ptr, excluding nothing else; if none, grant SHALL become 0 and state IDLE.
REQ-017 Back-to-back releases SHALL lose zero cycles between grants: the new grant appears the cycle immediately after release.
REQ-018 Without release, grant and ptr SHALL hold, regardless of other req changes.
REQ-019 A requester releasing and still requesting SHALL be re-granted only if no other req bit is set.
REQ-020 grant_id SHALL be registered with grant and never disagree with it.

Reset
REQ-021 With nreset=0 at a clock edge: grant=0, grant_id=0, state=IDLE, ptr=PTR_INIT; valid therefore 0.
REQ-022 Reset asserted mid-BUSY SHALL drop grant at that edge with no release side effects; arbitration restarts from PTR_INIT.
REQ-023 The first edge with nreset=1 SHALL behave as IDLE per REQ-012.

Configuration
REQ-024 With macro RR_ARB8_LOCK_EN defined, a transfer SHALL release only when last[grant_id]=1; multi-beat packets hold the grant.
REQ-025 Without RR_ARB8_LOCK_EN, every transfer SHALL release and last SHALL be ignored.

Structure
REQ-026 Shared package arb_pkg SHALL hold ARB_N=8, ARB_IW=3, and the IDLE/BUSY state typedef.
REQ-027 The combinational masked round-robin picker SHALL be a sub-module rr_pick8 (inputs req, ptr; output one-hot winner, index, any).
REQ-028 All outputs SHALL be flop-driven except valid.

Verification
REQ-029 Reset, then req=8'h81, ready=1, no lock: grants 8'h01, 8'h80, 8'h01 on consecutive cycles, grant_id 0,7,0.
REQ-030 req=8'hFF held, ready=1, no lock: grant walks 01,02,04,...,80,01 one step per cycle; no zero cycles.
REQ-031 Granted req bit dropped with ready=0: grant moves to next requester next cycle; ptr advances past abandoned index.
REQ-032 LOCK_EN, req=8'h03, requester 0 sends 3 beats with last on beat 3, ready=1: grant stays 8'h01 three cycles, then 8'h02.
REQ-033 ready=0 for 5 cycles with req=8'h04: grant holds 8'h04, valid=1 throughout; no rotation.
REQ-034 nreset pulsed low while grant=8'h10, PTR_INIT=5, req=8'h30: grant 0 during reset, then 8'h20 first cycle after.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter constants and the two-state arbiter FSM encoding.
package arb_pkg;
   localparam int ARB_N  = 8;
   localparam int ARB_IW = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;
endpackage

// File: rtl/rr_pick8.sv
// Combinational masked round-robin picker: first set req bit at or above ptr,
// wrapping to the lowest set bit when nothing at or above ptr is requesting.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [ARB_N-1:0]  req,
   input  logic [ARB_IW-1:0] ptr,
   output logic [ARB_N-1:0]  win,
   output logic [ARB_IW-1:0] idx,
   output logic              any
);

   logic [ARB_N-1:0] w_mask;
   logic [ARB_N-1:0] w_hi;
   logic [ARB_N-1:0] w_sel;

   assign w_mask = {ARB_N{1'b1}} << ptr;
   assign w_hi   = req & w_mask;
   assign w_sel  = (|w_hi) ? w_hi : req;
   // Isolate the lowest set bit of the selected vector.
   assign win    = w_sel & (~w_sel + 1'b1);
   assign any    = |req;

   always_comb begin
      idx = '0;
      for (int i = 0; i < ARB_N; i++) begin
         if (win[i]) idx = ARB_IW'(i);
      end
   end

endmodule

// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter with registered one-hot grant and binary grant_id.
// Define RR_ARB8_LOCK_EN to hold the grant across multi-beat packets until last.
module rr_arb8
   import arb_pkg::*;
#(
   parameter int PTR_INIT = 0
)(
   input  logic              clk,
   input  logic              nreset,
   input  logic [ARB_N-1:0]  req,
   input  logic [ARB_N-1:0]  last,
   input  logic              ready,
   output logic [ARB_N-1:0]  grant,
   output logic [ARB_IW-1:0] grant_id,
   output logic              valid
);

   localparam logic [ARB_IW-1:0] PTR_RST = ARB_IW'(PTR_INIT);

   arb_state_e        r_state;
   logic [ARB_N-1:0]  r_grant;
   logic [ARB_IW-1:0] r_gid;
   logic [ARB_IW-1:0] r_ptr;

   arb_state_e        w_state_nx;
   logic [ARB_N-1:0]  w_grant_nx;
   logic [ARB_IW-1:0] w_gid_nx;
   logic [ARB_IW-1:0] w_ptr_nx;

   logic [ARB_IW-1:0] w_gid_inc;
   logic [ARB_IW-1:0] w_pick_ptr;
   logic [ARB_N-1:0]  w_win;
   logic [ARB_IW-1:0] w_idx;
   logic              w_any;
   logic              w_valid;
   logic              w_last_ok;
   logic              w_rel;

   assign w_gid_inc  = r_gid + 3'd1;
   // While busy the picker already looks one past the current owner, so a
   // release can hand over in the very next cycle.
   assign w_pick_ptr = (r_state == BUSY) ? w_gid_inc : r_ptr;
   assign w_valid    = |(r_grant & req);

`ifdef RR_ARB8_LOCK_EN
   assign w_last_ok  = last[r_gid];
`else
   // last carries no meaning here; every transfer ends the grant.
   assign w_last_ok  = last[r_gid] | 1'b1;
`endif

   assign w_rel = (r_state == BUSY) &&
                  (!req[r_gid] || (w_valid && ready && w_last_ok));

   rr_pick8 u_pick (
      .req (req),
      .ptr (w_pick_ptr),
      .win (w_win),
      .idx (w_idx),
      .any (w_any)
   );

   always_comb begin
      w_state_nx = r_state;
      w_grant_nx = r_grant;
      w_gid_nx   = r_gid;
      w_ptr_nx   = r_ptr;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nx = BUSY;
               w_grant_nx = w_win;
               w_gid_nx   = w_idx;
            end
         end
         BUSY: begin
            if (w_rel) begin
               w_ptr_nx = w_gid_inc;
               if (w_any) begin
                  w_grant_nx = w_win;
                  w_gid_nx   = w_idx;
               end else begin
                  w_state_nx = IDLE;
                  w_grant_nx = '0;
                  w_gid_nx   = '0;
               end
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_grant_nx = '0;
            w_gid_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_gid   <= '0;
         r_ptr   <= PTR_RST;
      end else begin
         r_state <= w_state_nx;
         r_grant <= w_grant_nx;
         r_gid   <= w_gid_nx;
         r_ptr   <= w_ptr_nx;
      end
   end

   assign grant    = r_grant;
   assign grant_id = r_gid;
   assign valid    = w_valid;

endmodule
